idft_wb_master: RTL and testbench



---
 rtl/idft_wb_master.sv | 252 +++++++++++++++++++++++++
 tb/tb_idft_wb_master.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idft_wb_master.sv
// Wishbone classic master that loads 8 complex points into the IDFT slave,
// starts it, polls for completion and streams the 8 results back out.
module idft_wb_master #(
    parameter int NPTS     = 8,
    parameter int POLL_MAX = 1000,
    parameter int ACK_MAX  = 64
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [7:0]  ADR_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_real,
    input  logic [31:0] in_imag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_real,
    output logic [31:0] out_imag,
    output logic        out_last,
    output logic        busy,
    output logic        err,
    output logic [15:0] frame_cnt
);
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int AW = $clog2(ACK_MAX + 1);
    localparam logic [2:0]    LAST_IDX  = 3'(NPTS - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_RE,
        S_WR_IM,
        S_START,
        S_POLL,
        S_RD_RE,
        S_RD_IM,
        S_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [7:0]      adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [AW-1:0]   ackCnt_q, ackCnt_d;
    logic [PW-1:0]   pollCnt_q, pollCnt_d;
    logic [31:0]     inReal_q, inReal_d;
    logic [31:0]     inImag_q, inImag_d;
    logic [31:0]     outReal_q, outReal_d;
    logic [31:0]     outImag_q, outImag_d;
    logic            err_q, err_d;
    logic [15:0]     frameCnt_q, frameCnt_d;

    logic            isBus;
    logic            busWe;
    logic [7:0]      busAdr;
    logic [31:0]     busDat;
    logic            busDone;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            ackCnt_q   <= '0;
            pollCnt_q  <= '0;
            inReal_q   <= '0;
            inImag_q   <= '0;
            outReal_q  <= '0;
            outImag_q  <= '0;
            err_q      <= 1'b0;
            frameCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            ackCnt_q   <= ackCnt_d;
            pollCnt_q  <= pollCnt_d;
            inReal_q   <= inReal_d;
            inImag_q   <= inImag_d;
            outReal_q  <= outReal_d;
            outImag_q  <= outImag_d;
            err_q      <= err_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        ackCnt_d   = ackCnt_q;
        pollCnt_d  = pollCnt_q;
        inReal_d   = inReal_q;
        inImag_d   = inImag_q;
        outReal_d  = outReal_q;
        outImag_d  = outImag_q;
        err_d      = err_q;
        frameCnt_d = frameCnt_q;
        isBus      = 1'b1;
        busWe      = 1'b0;
        busAdr     = 8'h00;
        busDat     = 32'h0;
        busDone    = 1'b0;

        case (state_q)
            S_WR_RE: begin
                busWe  = 1'b1;
                busAdr = {5'h02, idx_q};
                busDat = inReal_q;
            end
            S_WR_IM: begin
                busWe  = 1'b1;
                busAdr = {5'h04, idx_q};
                busDat = inImag_q;
            end
            S_START: begin
                busWe  = 1'b1;
                busAdr = 8'h00;
                busDat = 32'h1;
            end
            S_POLL:  busAdr = 8'h08;
            S_RD_RE: busAdr = {5'h06, idx_q};
            S_RD_IM: busAdr = {5'h08, idx_q};
            default: isBus = 1'b0;
        endcase

        // Every bus state enters with CYC low, which doubles as the mandatory
        // idle cycle after the previous ACK; the next edge launches the cycle.
        if (isBus) begin
            if (!cyc_q) begin
                cyc_d    = 1'b1;
                we_d     = busWe;
                adr_d    = busAdr;
                dat_d    = busDat;
                ackCnt_d = '0;
            end else if (ACK_I) begin
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                busDone = 1'b1;
            end else if (ackCnt_q == ACK_LAST) begin
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                err_d   = 1'b1;
                idx_d   = '0;
                state_d = S_IDLE;
            end else begin
                ackCnt_d = ackCnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    inReal_d = in_real;
                    inImag_d = in_imag;
                    state_d  = S_WR_RE;
                end
            end
            S_WR_RE: begin
                if (busDone) state_d = S_WR_IM;
            end
            S_WR_IM: begin
                if (busDone) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_START;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_START: begin
                if (busDone) begin
                    pollCnt_d = '0;
                    state_d   = S_POLL;
                end
            end
            S_POLL: begin
                if (busDone) begin
                    if (DAT_I[0]) begin
                        state_d = S_RD_RE;
                    end else if (pollCnt_q == POLL_LAST) begin
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        pollCnt_d = pollCnt_q + 1'b1;
                    end
                end
            end
            S_RD_RE: begin
                if (busDone) begin
                    outReal_d = DAT_I;
                    state_d   = S_RD_IM;
                end
            end
            S_RD_IM: begin
                if (busDone) begin
                    outImag_d = DAT_I;
                    state_d   = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d      = '0;
                        frameCnt_d = frameCnt_q + 16'd1;
                        state_d    = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_RD_RE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gated by reset so every output reads zero while RST_I is held.
    assign in_ready  = (state_q == S_IDLE) && !RST_I;
    assign CYC_O     = cyc_q;
    assign STB_O     = cyc_q;
    assign WE_O      = we_q;
    assign ADR_O     = adr_q;
    assign DAT_O     = dat_q;
    assign out_valid = (state_q == S_OUT);
    assign out_last  = (state_q == S_OUT) && (idx_q == LAST_IDX);
    assign out_real  = outReal_q;
    assign out_imag  = outImag_q;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign frame_cnt = frameCnt_q;
endmodule

// File: tb/tb_idft_wb_master.sv
// Self-checking bench for idft_wb_master: a mock IDFT slave answers the bus,
// and scoreboards hold the expected bus trace and output points per frame.
module tb_idft_wb_master;
    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic        CYC_O, STB_O, WE_O;
    logic [7:0]  ADR_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic        ACK_I;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_real = 32'h0;
    logic [31:0] in_imag = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_real, out_imag;
    logic        out_last, busy, err;
    logic [15:0] frame_cnt;

    int testsRun = 0;
    int testsFailed = 0;

    // Mock slave state
    int          waitCnt = 0;
    int          curLat = 0;
    int          writesAcked = 0;
    int          statusReads = 0;
    bit          randomAck = 1'b0;
    int          doneAfter = 3;
    bit          withholdOn = 1'b0;
    int          withholdAt = 0;
    logic [31:0] yReal [8];
    logic [31:0] yImag [8];
    logic        mockDone;

    logic [31:0] ptRe [8];
    logic [31:0] ptIm [8];

    typedef logic [40:0] busRec_t;
    busRec_t     busObs[$];
    busRec_t     busExp[$];
    logic [64:0] outExp[$];

    idft_wb_master dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
        .DAT_I(DAT_I), .ACK_I(ACK_I),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
        .out_last(out_last), .busy(busy), .err(err), .frame_cnt(frame_cnt)
    );

    always #5 CLK_I = ~CLK_I;

    assign mockDone = (doneAfter != 0) && (statusReads + 1 >= doneAfter);
    assign ACK_I = CYC_O && STB_O && (waitCnt >= curLat)
                   && !(withholdOn && WE_O && (writesAcked == withholdAt));

    always_comb begin
        DAT_I = 32'h0;
        if (ADR_O == 8'h08) DAT_I = {31'h0, mockDone};
        else if (ADR_O[7:3] == 5'h06) DAT_I = yReal[ADR_O[2:0]];
        else if (ADR_O[7:3] == 5'h08) DAT_I = yImag[ADR_O[2:0]];
    end

    always @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            waitCnt <= 0;
            curLat  <= 0;
        end else if (CYC_O && STB_O) begin
            if (ACK_I) begin
                waitCnt <= 0;
                curLat  <= randomAck ? int'($urandom_range(0, 7)) : 0;
                if (WE_O) writesAcked <= writesAcked + 1;
                if (WE_O && ADR_O == 8'h00) statusReads <= 0;
                if (!WE_O && ADR_O == 8'h08) statusReads <= statusReads + 1;
            end else begin
                waitCnt <= waitCnt + 1;
            end
        end else begin
            waitCnt <= 0;
        end
    end

    // Completed bus cycles are logged mid-cycle, one half period before the edge that takes the ACK.
    always @(negedge CLK_I) begin
        if (!RST_I && CYC_O && STB_O && ACK_I)
            busObs.push_back({WE_O, ADR_O, WE_O ? DAT_O : 32'h0});
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic applyReset();
        RST_I = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        tick();
    endtask

    task automatic feedPoints(input bit rnd, input int count, output bit ok);
        bit seen;
        ok = 1'b1;
        for (int i = 0; i < count; i++) begin
            if (rnd) repeat ($urandom_range(0, 3)) tick();
            in_valid = 1'b1;
            in_real  = ptRe[i];
            in_imag  = ptIm[i];
            seen = 1'b0;
            for (int c = 0; c < 2000 && !seen; c++) begin
                @(negedge CLK_I);
                if (in_ready) seen = 1'b1;
                @(posedge CLK_I);
                #1;
            end
            in_valid = 1'b0;
            testsRun++;
            if (!seen) begin
                testsFailed++;
                $display("[TB] FAIL in_handshake point %0d: in_ready=0, required 1", i);
                ok = 1'b0;
                return;
            end
        end
    endtask

    // Builds the expected bus trace and outputs, runs one frame, then checks both.
    task automatic runFrame(input bit rnd, input int stallAt);
        logic [64:0] expOut;
        int          got;
        int          cycles;
        bit          ok;
        bit          stalled;
        busObs.delete();
        busExp.delete();
        outExp.delete();
        for (int i = 0; i < 8; i++) begin
            ptRe[i]  = rnd ? $urandom : 32'(i * 10);
            ptIm[i]  = rnd ? $urandom : 32'(-i);
            yReal[i] = $urandom;
            yImag[i] = $urandom;
            busExp.push_back({1'b1, 8'h10 + 8'(i), ptRe[i]});
            busExp.push_back({1'b1, 8'h20 + 8'(i), ptIm[i]});
        end
        busExp.push_back({1'b1, 8'h00, 32'h1});
        for (int p = 0; p < doneAfter; p++) busExp.push_back({1'b0, 8'h08, 32'h0});
        for (int i = 0; i < 8; i++) begin
            busExp.push_back({1'b0, 8'h30 + 8'(i), 32'h0});
            busExp.push_back({1'b0, 8'h40 + 8'(i), 32'h0});
            outExp.push_back({(i == 7), yReal[i], yImag[i]});
        end

        feedPoints(rnd, 8, ok);
        if (!ok) return;

        got = 0;
        cycles = 0;
        stalled = 1'b0;
        while (got < 8 && cycles < 4000) begin
            if (got == stallAt && !stalled && out_valid && outExp.size() > 0) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge CLK_I);
                    testsRun++;
                    if (out_valid !== 1'b1 || out_real !== outExp[0][63:32]
                        || out_imag !== outExp[0][31:0] || CYC_O !== 1'b0) begin
                        testsFailed++;
                        $display("[TB] FAIL stall_hold cycle %0d: valid=%b real=%h imag=%h cyc=%b, required valid=1 real=%h imag=%h cyc=0",
                                 s, out_valid, out_real, out_imag, CYC_O, outExp[0][63:32], outExp[0][31:0]);
                    end
                    @(posedge CLK_I);
                    #1;
                end
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge CLK_I);
            if (out_valid && out_ready) begin
                testsRun++;
                if (outExp.size() == 0) begin
                    testsFailed++;
                    $display("[TB] FAIL extra_output: point %0d seen, required none", got);
                end else begin
                    expOut = outExp.pop_front();
                    if ({out_last, out_real, out_imag} !== expOut) begin
                        testsFailed++;
                        $display("[TB] FAIL output_point %0d: last=%b real=%h imag=%h, required last=%b real=%h imag=%h",
                                 got, out_last, out_real, out_imag, expOut[64], expOut[63:32], expOut[31:0]);
                    end
                end
                got++;
            end
            @(posedge CLK_I);
            #1;
            cycles++;
        end
        out_ready = 1'b0;

        testsRun++;
        if (got != 8) begin
            testsFailed++;
            $display("[TB] FAIL output_count: got %0d, required 8", got);
        end
        testsRun++;
        if (busObs.size() != busExp.size()) begin
            testsFailed++;
            $display("[TB] FAIL bus_trace_len: got %0d, required %0d", busObs.size(), busExp.size());
        end
        for (int k = 0; k < busExp.size() && k < busObs.size(); k++) begin
            testsRun++;
            if (busObs[k] !== busExp[k]) begin
                testsFailed++;
                $display("[TB] FAIL bus_trace[%0d]: we=%b adr=%h dat=%h, required we=%b adr=%h dat=%h",
                         k, busObs[k][40], busObs[k][39:32], busObs[k][31:0],
                         busExp[k][40], busExp[k][39:32], busExp[k][31:0]);
            end
        end
    endtask

    task automatic test_reset();
        RST_I = 1'b1;
        repeat (3) @(posedge CLK_I);
        @(negedge CLK_I);
        testsRun++;
        if ({CYC_O, STB_O, WE_O, ADR_O, DAT_O} !== 43'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_bus: cyc=%b stb=%b we=%b adr=%h dat=%h, required all 0",
                     CYC_O, STB_O, WE_O, ADR_O, DAT_O);
        end
        testsRun++;
        if ({in_ready, out_valid, out_last, out_real, out_imag} !== 67'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_stream: in_ready=%b out_valid=%b last=%b real=%h imag=%h, required all 0",
                     in_ready, out_valid, out_last, out_real, out_imag);
        end
        testsRun++;
        if ({busy, err, frame_cnt} !== 18'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_status: busy=%b err=%b frame_cnt=%0d, required 0 0 0", busy, err, frame_cnt);
        end
        @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        tick();
        testsRun++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL idle_after_reset: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_basic_frame();
        doneAfter = 3;
        runFrame(1'b0, -1);
        testsRun++;
        if (frame_cnt !== 16'd1 || busy !== 1'b0 || err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL basic_status: frame_cnt=%0d busy=%b err=%b, required 1 0 0", frame_cnt, busy, err);
        end
    endtask

    task automatic test_backpressure();
        doneAfter = 3;
        runFrame(1'b0, 3);
        testsRun++;
        if (frame_cnt !== 16'd2) begin
            testsFailed++;
            $display("[TB] FAIL backpressure_frames: frame_cnt=%0d, required 2", frame_cnt);
        end
    endtask

    task automatic test_poll_timeout();
        bit ok;
        bit sawValid;
        bit sawErr;
        doneAfter = 0;
        for (int i = 0; i < 8; i++) begin
            ptRe[i] = 32'h100 + 32'(i);
            ptIm[i] = 32'h200 + 32'(i);
        end
        feedPoints(1'b0, 8, ok);
        sawValid = 1'b0;
        sawErr = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5000 && !sawErr; c++) begin
            @(negedge CLK_I);
            if (out_valid) sawValid = 1'b1;
            if (err) sawErr = 1'b1;
            @(posedge CLK_I);
            #1;
        end
        repeat (10) begin
            @(negedge CLK_I);
            if (out_valid) sawValid = 1'b1;
        end
        out_ready = 1'b0;
        testsRun++;
        if (!sawErr || statusReads != 1000) begin
            testsFailed++;
            $display("[TB] FAIL poll_timeout: err_seen=%b status_reads=%0d, required 1 1000", sawErr, statusReads);
        end
        testsRun++;
        if (err !== 1'b1 || busy !== 1'b0 || sawValid) begin
            testsFailed++;
            $display("[TB] FAIL poll_timeout_state: err=%b busy=%b out_valid_seen=%b, required 1 0 0", err, busy, sawValid);
        end
        tick();
        doneAfter = 3;
        runFrame(1'b0, -1);
        testsRun++;
        if (frame_cnt !== 16'd3 || err !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL after_poll_timeout: frame_cnt=%0d err=%b, required 3 1", frame_cnt, err);
        end
    endtask

    task automatic test_ack_timeout();
        bit ok;
        bit sawErr;
        int cycHigh;
        applyReset();
        doneAfter = 3;
        for (int i = 0; i < 8; i++) begin
            ptRe[i] = 32'hA000 + 32'(i);
            ptIm[i] = 32'hB000 + 32'(i);
        end
        withholdAt = writesAcked + 4;
        withholdOn = 1'b1;
        feedPoints(1'b0, 3, ok);
        cycHigh = 0;
        sawErr = 1'b0;
        for (int c = 0; c < 300 && !sawErr; c++) begin
            @(negedge CLK_I);
            if (err) sawErr = 1'b1;
            else if (CYC_O) cycHigh++;
            @(posedge CLK_I);
            #1;
        end
        withholdOn = 1'b0;
        testsRun++;
        if (!sawErr || cycHigh != 64) begin
            testsFailed++;
            $display("[TB] FAIL ack_timeout: err_seen=%b cyc_high_cycles=%0d, required 1 64", sawErr, cycHigh);
        end
        testsRun++;
        if (CYC_O !== 1'b0 || err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL ack_timeout_state: cyc=%b err=%b busy=%b in_ready=%b, required 0 1 0 1",
                     CYC_O, err, busy, in_ready);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        bit found;
        doneAfter = 0;
        for (int i = 0; i < 8; i++) begin
            ptRe[i] = 32'(i);
            ptIm[i] = 32'(i + 100);
        end
        feedPoints(1'b0, 8, ok);
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge CLK_I);
            if (statusReads >= 2 && STB_O && ADR_O == 8'h08) found = 1'b1;
            else begin
                @(posedge CLK_I);
                #1;
            end
        end
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("[TB] FAIL reach_poll: poll cycle not seen, required STB_O=1 at 0x08");
        end
        #2;
        RST_I = 1'b1;
        #1;
        testsRun++;
        if (CYC_O !== 1'b0 || STB_O !== 1'b0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: cyc=%b stb=%b busy=%b, required 0 0 0", CYC_O, STB_O, busy);
        end
        testsRun++;
        if (frame_cnt !== 16'd0 || err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset_status: frame_cnt=%0d err=%b, required 0 0", frame_cnt, err);
        end
        repeat (2) @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        tick();
        doneAfter = 3;
        runFrame(1'b0, -1);
        testsRun++;
        if (frame_cnt !== 16'd1) begin
            testsFailed++;
            $display("[TB] FAIL after_async_reset: frame_cnt=%0d, required 1", frame_cnt);
        end
    endtask

    task automatic test_random_frames();
        applyReset();
        randomAck = 1'b1;
        for (int f = 0; f < 20; f++) begin
            doneAfter = int'($urandom_range(1, 4));
            runFrame(1'b1, -1);
        end
        randomAck = 1'b0;
        testsRun++;
        if (frame_cnt !== 16'd20 || err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL random_frames: frame_cnt=%0d err=%b, required 20 0", frame_cnt, err);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_poll_timeout();
        test_ack_timeout();
        test_async_reset();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
